dds_wave_sched: RTL and testbench
=================================

Name: dds_wave_sched

Overview:
Waveform scheduler and configuration controller for the DDS core. It sequences the one-hot waveform select through sine, square, triangle, sawtooth and off. Advances come from a dwell timer (auto mode) or from a manual advance pulse. It also owns the DDS frequency control word and pulses a phase clear on every waveform change. It sits between the key/debounce logic and the dds instance, driving its wave_select directly.

Parameters:
DWELL_CYC, 400000, RUN cycles per waveform in auto mode (8 ms at 50 MHz); legal range is 2 or more.
FW_W, 32, frequency word width.
FW_DEFAULT, 32'd85899, frequency word after reset and after wrap.
FW_STEP, 32'd85899, increment per key_freq pulse.
FW_MAX, 32'd858993, largest legal frequency word.

Ports:
sys_clk  in  1  system clock.
sys_rst  in  1  reset; asynchronous, active-high.
start  in  1  one-cycle pulse; leave IDLE and begin at sine.
stop  in  1  one-cycle pulse; return to IDLE.
key_next  in  1  one-cycle pulse; advance to the next waveform immediately.
key_freq  in  1  one-cycle pulse; step the frequency word.
auto_en  in  1  level; enables dwell-timer advance.
hold  in  1  level; freezes the dwell counter.
wave_select  out  4  one-hot waveform to the DDS: 0001 sine, 0010 square, 0100 triangle, 1000 saw, 0000 off.
freq_word  out  FW_W  DDS frequency control word.
phase_clr  out  1  one-cycle pulse; clear the DDS phase accumulator.
wave_valid  out  1  high in RUN while wave_select is not 0000.

Behaviour:
- Clock and reset: single clock domain, sys_clk. Reset is asynchronous and active-high (sys_rst). All outputs are registered.
- Reset values:
  - state IDLE, slot index 0, dwell counter 0.
  - wave_select 0000, freq_word FW_DEFAULT, phase_clr 0, wave_valid 0.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.
- Slot sequence: 0 sine, 1 square, 2 triangle, 3 saw, 4 off (0000), then back to 0.
- States:
  - IDLE: wave_select 0000. On start: slot <= 0, go to SWITCH. All other controls except key_freq are ignored.
  - SWITCH: lasts exactly one cycle. phase_clr=1 and wave_select shows the new slot. Dwell counter cleared. Next state is RUN. key_next and start are ignored here.
  - RUN:
    - Dwell counter increments each cycle unless hold=1.
    - Advance condition: (auto_en=1, hold=0 and counter=DWELL_CYC-1) or key_next=1. On advance: slot <= (slot+1) mod 5, go to SWITCH.
    - A dwell expiry and key_next in the same cycle advance exactly one slot.
    - auto_en=0 with hold=0 still lets the counter run, but it saturates at DWELL_CYC-1 and causes no advance.
- Priority: stop beats key_next, which beats dwell expiry. stop in SWITCH or RUN goes to IDLE and registers wave_select 0000 on the next edge. start outside IDLE is ignored.
- Latency: an event sampled in cycle N gives the new wave_select plus phase_clr in cycle N+1, and RUN in N+2.
- Auto period: DWELL_CYC+1 cycles per slot (1 SWITCH + DWELL_CYC RUN).
- Frequency word: updated on key_freq in any state, including IDLE.
  - If freq_word+FW_STEP > FW_MAX, freq_word <= FW_DEFAULT; otherwise freq_word <= freq_word+FW_STEP.
  - Compare in FW_W+1 bits so the sum cannot overflow.
  - A frequency change does not pulse phase_clr.
- wave_valid is 0 in IDLE and SWITCH, and 0 in RUN when the slot is off.

Optional Feature:
Macro DDS_SCHED_SKIP_OFF_EN.
- Defined: the off slot is removed. The sequence is 4 slots, saw goes to sine, the slot counter wraps mod 4, and wave_select is never 0000 outside IDLE.
- Undefined: 5-slot sequence including off, as described above.

Test Plan:
1. Reset check. Hold sys_rst=1, then release. Expect wave_select 0000, freq_word FW_DEFAULT, phase_clr 0 and wave_valid 0, and all of these still true 10 cycles after release with no stimulus.
2. Auto sequence. DWELL_CYC=10, auto_en=1, start pulse at cycle N. Expect:
   - 0001 with phase_clr=1 at N+1.
   - 0010 at N+12, 0100 at N+23, 1000 at N+34, 0000 at N+45 (wave_valid=0), 0001 at N+56.
   - Each change coincides with a single-cycle phase_clr.
3. Manual advance. auto_en=0, three key_next pulses spaced 5 cycles apart. Expect 0001, 0010, 0100, 1000 with no timer advance after 50 idle cycles. key_next coincident with dwell expiry (auto_en=1) advances exactly one slot.
4. Hold. DWELL_CYC=10, hold=1 for 5 cycles mid-dwell. Expect the next change delayed by exactly 5 cycles (16 cycles instead of 11).
5. Frequency wrap. FW_DEFAULT=100, FW_STEP=50, FW_MAX=200, three key_freq pulses. Expect freq_word 150, then 200, then 100, with no phase_clr.
6. Stop and async reset.
   - stop in RUN: wave_select 0000 on the next cycle, then a start pulse restarts at 0001.
   - sys_rst asserted between clock edges in RUN: outputs return to reset values before the next sys_clk edge.
   - With DDS_SCHED_SKIP_OFF_EN defined: saw goes directly to sine.

Source files
------------

// File: rtl/dds_wave_sched.sv
// Purpose : DDS waveform scheduler: walks the one-hot wave_select through sine,
//           square, triangle, saw, off using a dwell timer or a manual advance
//           pulse, owns the frequency word and pulses phase_clr on each change.
// Ports   : sys_clk/sys_rst (async active-high); start/stop/key_next/key_freq
//           pulses; auto_en/hold levels; wave_select, freq_word, phase_clr,
//           wave_valid registered outputs.
// Latency : an event in cycle N shows the new wave_select + phase_clr in N+1, RUN in N+2.
// Option  : DDS_SCHED_SKIP_OFF_EN drops the off slot (4-slot sequence, saw -> sine).
module dds_wave_sched #(
    parameter int              DWELL_CYC  = 400000,
    parameter int              FW_W       = 32,
    parameter logic [FW_W-1:0] FW_DEFAULT = 32'd85899,
    parameter logic [FW_W-1:0] FW_STEP    = 32'd85899,
    parameter logic [FW_W-1:0] FW_MAX     = 32'd858993
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic            stop,
    input  logic            key_next,
    input  logic            key_freq,
    input  logic            auto_en,
    input  logic            hold,
    output logic [3:0]      wave_select,
    output logic [FW_W-1:0] freq_word,
    output logic            phase_clr,
    output logic            wave_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SWITCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

`ifdef DDS_SCHED_SKIP_OFF_EN
    localparam logic [2:0] LAST_SLOT = 3'd3;
`else
    localparam logic [2:0] LAST_SLOT = 3'd4;
`endif
    localparam logic [2:0] OFF_SLOT  = 3'd4;

    localparam int              CNT_W    = (DWELL_CYC > 2) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);

    localparam logic [FW_W:0] FW_MAX_X  = {1'b0, FW_MAX};
    localparam logic [FW_W:0] FW_STEP_X = {1'b0, FW_STEP};

    logic [1:0]       state;
    logic [2:0]       slot;
    logic [CNT_W-1:0] dwell_cnt;
    logic [2:0]       slot_nxt;
    logic             dwell_done;
    logic             advance;
    logic [FW_W:0]    fw_sum;

    function automatic logic [3:0] slot_onehot(input logic [2:0] s);
        case (s)
            3'd0:    slot_onehot = 4'b0001;
            3'd1:    slot_onehot = 4'b0010;
            3'd2:    slot_onehot = 4'b0100;
            3'd3:    slot_onehot = 4'b1000;
            default: slot_onehot = 4'b0000;
        endcase
    endfunction

    assign slot_nxt   = (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
    assign dwell_done = auto_en && !hold && (dwell_cnt == CNT_LAST);
    // key_next and dwell expiry together still produce a single advance.
    assign advance    = key_next || dwell_done;
    // One extra bit so the step can never wrap before the limit compare.
    assign fw_sum     = {1'b0, freq_word} + FW_STEP_X;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            slot        <= 3'd0;
            dwell_cnt   <= '0;
            wave_select <= 4'b0000;
            phase_clr   <= 1'b0;
            wave_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wave_valid <= 1'b0;
                    if (start) begin
                        state       <= ST_SWITCH;
                        slot        <= 3'd0;
                        dwell_cnt   <= '0;
                        wave_select <= slot_onehot(3'd0);
                        phase_clr   <= 1'b1;
                    end else begin
                        wave_select <= 4'b0000;
                        phase_clr   <= 1'b0;
                    end
                end
                ST_SWITCH: begin
                    phase_clr <= 1'b0;
                    dwell_cnt <= '0;
                    if (stop) begin
                        state       <= ST_IDLE;
                        wave_select <= 4'b0000;
                        wave_valid  <= 1'b0;
                    end else begin
                        state      <= ST_RUN;
                        wave_valid <= (slot != OFF_SLOT);
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state       <= ST_IDLE;
                        wave_select <= 4'b0000;
                        wave_valid  <= 1'b0;
                        phase_clr   <= 1'b0;
                    end else if (advance) begin
                        state       <= ST_SWITCH;
                        slot        <= slot_nxt;
                        dwell_cnt   <= '0;
                        wave_select <= slot_onehot(slot_nxt);
                        phase_clr   <= 1'b1;
                        wave_valid  <= 1'b0;
                    end else begin
                        phase_clr <= 1'b0;
                        // Saturates at the last count so auto_en=0 just parks here.
                        if (!hold && (dwell_cnt != CNT_LAST)) begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    wave_select <= 4'b0000;
                    phase_clr   <= 1'b0;
                    wave_valid  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            freq_word <= FW_DEFAULT;
        end else if (key_freq) begin
            if (fw_sum > FW_MAX_X) begin
                freq_word <= FW_DEFAULT;
            end else begin
                freq_word <= fw_sum[FW_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dds_wave_sched.sv
module tb_dds_wave_sched;

    logic        sys_clk;
    logic        sys_rst;
    logic        start;
    logic        stop;
    logic        key_next;
    logic        key_freq;
    logic        auto_en;
    logic        hold;
    logic [3:0]  wave_select;
    logic [31:0] freq_word;
    logic        phase_clr;
    logic        wave_valid;

    int checks = 0;
    int errors = 0;

    dds_wave_sched #(
        .DWELL_CYC (10),
        .FW_W      (32),
        .FW_DEFAULT(32'd100),
        .FW_STEP   (32'd50),
        .FW_MAX    (32'd200)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .stop       (stop),
        .key_next   (key_next),
        .key_freq   (key_freq),
        .auto_en    (auto_en),
        .hold       (hold),
        .wave_select(wave_select),
        .freq_word  (freq_word),
        .phase_clr  (phase_clr),
        .wave_valid (wave_valid)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next n rising edges.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(1); stop = 1'b0;
    endtask

    task automatic pulse_next();
        key_next = 1'b1; tick(1); key_next = 1'b0;
    endtask

    task automatic pulse_freq();
        key_freq = 1'b1; tick(1); key_freq = 1'b0;
    endtask

    initial begin
        sys_rst  = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        key_next = 1'b0;
        key_freq = 1'b0;
        auto_en  = 1'b0;
        hold     = 1'b0;

        // 1. reset
        tick(3);
        check("rst_ws",   32'(wave_select), 32'h0);
        check("rst_fw",   freq_word,        32'd100);
        check("rst_pc",   32'(phase_clr),   32'h0);
        check("rst_wv",   32'(wave_valid),  32'h0);
        sys_rst = 1'b0;
        tick(10);
        check("idle10_ws", 32'(wave_select), 32'h0);
        check("idle10_fw", freq_word,        32'd100);
        check("idle10_pc", 32'(phase_clr),   32'h0);
        check("idle10_wv", 32'(wave_valid),  32'h0);

        // 2. auto sequence, start sampled in cycle N
        auto_en = 1'b1;
        pulse_start();                                   // N+1
        check("auto_n1_ws", 32'(wave_select), 32'h1);
        check("auto_n1_pc", 32'(phase_clr),   32'h1);
        check("auto_n1_wv", 32'(wave_valid),  32'h0);
        tick(1);                                         // N+2
        check("auto_n2_pc", 32'(phase_clr),   32'h0);
        check("auto_n2_wv", 32'(wave_valid),  32'h1);
        tick(9);                                         // N+11
        check("auto_n11_ws", 32'(wave_select), 32'h1);
        tick(1);                                         // N+12
        check("auto_n12_ws", 32'(wave_select), 32'h2);
        check("auto_n12_pc", 32'(phase_clr),   32'h1);
        tick(11);                                        // N+23
        check("auto_n23_ws", 32'(wave_select), 32'h4);
        check("auto_n23_pc", 32'(phase_clr),   32'h1);
        tick(11);                                        // N+34
        check("auto_n34_ws", 32'(wave_select), 32'h8);
        check("auto_n34_pc", 32'(phase_clr),   32'h1);
        tick(11);                                        // N+45
`ifdef DDS_SCHED_SKIP_OFF_EN
        check("auto_n45_ws", 32'(wave_select), 32'h1);
        check("auto_n45_pc", 32'(phase_clr),   32'h1);
        tick(1);
        check("auto_n46_wv", 32'(wave_valid),  32'h1);
        tick(10);                                        // N+56
        check("auto_n56_ws", 32'(wave_select), 32'h2);
`else
        check("auto_n45_ws", 32'(wave_select), 32'h0);
        check("auto_n45_pc", 32'(phase_clr),   32'h1);
        tick(1);
        check("auto_n46_wv", 32'(wave_valid),  32'h0);
        tick(10);                                        // N+56
        check("auto_n56_ws", 32'(wave_select), 32'h1);
`endif
        check("auto_n56_pc", 32'(phase_clr),   32'h1);

        // 6a. stop in RUN, then idle stays off
        tick(1);
        pulse_stop();
        check("stop_ws", 32'(wave_select), 32'h0);
        check("stop_wv", 32'(wave_valid),  32'h0);
        check("stop_pc", 32'(phase_clr),   32'h0);
        tick(3);
        check("stop_idle_ws", 32'(wave_select), 32'h0);

        // 3. manual advance with the timer disabled
        auto_en = 1'b0;
        pulse_start();
        check("man_start_ws", 32'(wave_select), 32'h1);
        tick(4);
        pulse_next();
        check("man1_ws", 32'(wave_select), 32'h2);
        check("man1_pc", 32'(phase_clr),   32'h1);
        tick(4);
        pulse_next();
        check("man2_ws", 32'(wave_select), 32'h4);
        tick(4);
        pulse_next();
        check("man3_ws", 32'(wave_select), 32'h8);
        tick(50);
        check("man_idle50_ws", 32'(wave_select), 32'h8);
        check("man_idle50_pc", 32'(phase_clr),   32'h0);
        check("man_idle50_wv", 32'(wave_valid),  32'h1);
        // counter is parked at DWELL_CYC-1: enabling auto_en with key_next
        // makes expiry and key_next coincide
        auto_en  = 1'b1;
        key_next = 1'b1;
        tick(1);
        key_next = 1'b0;
        auto_en  = 1'b0;
`ifdef DDS_SCHED_SKIP_OFF_EN
        check("coinc_ws", 32'(wave_select), 32'h1);
`else
        check("coinc_ws", 32'(wave_select), 32'h0);
`endif
        check("coinc_pc", 32'(phase_clr),   32'h1);
        tick(2);
`ifdef DDS_SCHED_SKIP_OFF_EN
        check("coinc_after_ws", 32'(wave_select), 32'h1);
`else
        check("coinc_after_ws", 32'(wave_select), 32'h0);
`endif
        check("coinc_after_pc", 32'(phase_clr),   32'h0);
        pulse_stop();

        // 4. hold for 5 cycles mid-dwell, start sampled in cycle M
        auto_en = 1'b1;
        tick(2);
        pulse_start();                                   // M+1
        check("hold_m1_ws", 32'(wave_select), 32'h1);
        tick(3);                                         // M+4
        hold = 1'b1;
        tick(5);                                         // M+9
        hold = 1'b0;
        tick(7);                                         // M+16
        check("hold_m16_ws", 32'(wave_select), 32'h1);
        check("hold_m16_pc", 32'(phase_clr),   32'h0);
        tick(1);                                         // M+17
        check("hold_m17_ws", 32'(wave_select), 32'h2);
        check("hold_m17_pc", 32'(phase_clr),   32'h1);

        // 5. frequency stepping and wrap while running
        auto_en = 1'b0;
        tick(2);
        pulse_freq();
        check("fw1",    freq_word,        32'd150);
        check("fw1_pc", 32'(phase_clr),   32'h0);
        tick(1);
        pulse_freq();
        check("fw2",    freq_word,        32'd200);
        check("fw2_pc", 32'(phase_clr),   32'h0);
        tick(1);
        pulse_freq();
        check("fw3",    freq_word,        32'd100);
        check("fw3_pc", 32'(phase_clr),   32'h0);
        check("fw3_ws", 32'(wave_select), 32'h2);
        pulse_freq();
        check("fw4",    freq_word,        32'd150);

        // 6b. async reset between edges while in RUN
        #3;
        sys_rst = 1'b1;
        #1;
        check("arst_ws", 32'(wave_select), 32'h0);
        check("arst_fw", freq_word,        32'd100);
        check("arst_pc", 32'(phase_clr),   32'h0);
        check("arst_wv", 32'(wave_valid),  32'h0);
        tick(2);
        #2;
        sys_rst = 1'b0;
        tick(2);
        check("arst_rel_ws", 32'(wave_select), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
